// File: rtl/dmem_store_buffer_if.sv
// Bundles the core memory-stage port and the req/ack data bus of the store buffer.
// Bus handshake: bus_req qualifies bus_we/bus_addr/bus_wdata, which stay stable until the cycle bus_ack is high.
interface dmem_store_buffer_if;
    logic        cpu_memen;
    logic        cpu_memwrite;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        sb_empty;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport slave (
        input  cpu_memen, cpu_memwrite, cpu_addr, cpu_wdata, bus_ack, bus_rdata,
        output cpu_rdata, cpu_stall, sb_empty, bus_req, bus_we, bus_addr, bus_wdata
    );

    modport master (
        output cpu_memen, cpu_memwrite, cpu_addr, cpu_wdata, bus_ack, bus_rdata,
        input  cpu_rdata, cpu_stall, sb_empty, bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-store buffer in front of the data bus: stores queue in a FIFO and drain in the
// background, loads forward from buffered stores or stall for a bus read.
module dmem_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    dmem_store_buffer_if.slave           mem_if,
    output logic [1:0]                   dbg_state_o,
    output logic [$clog2(DEPTH+1)-1:0]   dbg_count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_e;

    state_e             state_q;
    logic [29:0]        addr_mem_q [DEPTH];
    logic [31:0]        data_mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;
    logic               bus_req_q, bus_we_q;
    logic [31:0]        bus_addr_q, bus_wdata_q;

    logic               is_load, is_store, full, load_miss;
    logic               wr_ack, rd_ack, push, pop;
    logic               fwd_hit;
    logic [31:0]        fwd_data;
    logic               have_first, have_second;
    logic [29:0]        first_addr, second_addr;
    logic [31:0]        first_data, second_data;
    logic [PTR_W-1:0]   head_nxt;
    logic               unused_addr_lsbs;

    assign unused_addr_lsbs = ^mem_if.cpu_addr[1:0];

    assign is_load   = mem_if.cpu_memen & ~mem_if.cpu_memwrite;
    assign is_store  = mem_if.cpu_memen &  mem_if.cpu_memwrite;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign wr_ack    = (state_q == S_WR) & mem_if.bus_ack;
    assign rd_ack    = (state_q == S_RD) & mem_if.bus_ack;
    assign push      = is_store & (~full | wr_ack);
    assign pop       = wr_ack;
    assign load_miss = is_load & ~fwd_hit;
    assign head_nxt  = head_q + PTR_W'(1);

    // Oldest-to-youngest scan so the youngest matching store wins; the in-flight head is included.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) &&
                (addr_mem_q[head_q + PTR_W'(i)] == mem_if.cpu_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem_q[head_q + PTR_W'(i)];
            end
        end
    end

    // Next write candidates; a store pushed this cycle can be issued directly when the FIFO runs dry.
    assign have_first  = (count_q != '0) | push;
    assign first_addr  = (count_q != '0) ? addr_mem_q[head_q] : mem_if.cpu_addr[31:2];
    assign first_data  = (count_q != '0) ? data_mem_q[head_q] : mem_if.cpu_wdata;
    assign have_second = (count_q > CNT_W'(1)) | push;
    assign second_addr = (count_q > CNT_W'(1)) ? addr_mem_q[head_nxt] : mem_if.cpu_addr[31:2];
    assign second_data = (count_q > CNT_W'(1)) ? data_mem_q[head_nxt] : mem_if.cpu_wdata;

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem_q[tail_q] <= mem_if.cpu_addr[31:2];
            data_mem_q[tail_q] <= mem_if.cpu_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_nxt;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_miss) begin
                        state_q    <= S_RD;
                        bus_req_q  <= 1'b1;
                        bus_we_q   <= 1'b0;
                        bus_addr_q <= {mem_if.cpu_addr[31:2], 2'b00};
                    end else if (have_first) begin
                        state_q     <= S_WR;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b1;
                        bus_addr_q  <= {first_addr, 2'b00};
                        bus_wdata_q <= first_data;
                    end
                end
                S_WR: begin
                    if (wr_ack) begin
                        if (load_miss) begin
                            state_q    <= S_RD;
                            bus_we_q   <= 1'b0;
                            bus_addr_q <= {mem_if.cpu_addr[31:2], 2'b00};
                        end else if (have_second) begin
                            bus_addr_q  <= {second_addr, 2'b00};
                            bus_wdata_q <= second_data;
                        end else begin
                            state_q   <= S_IDLE;
                            bus_req_q <= 1'b0;
                            bus_we_q  <= 1'b0;
                        end
                    end
                end
                S_RD: begin
                    if (rd_ack) begin
                        if (have_first) begin
                            state_q     <= S_WR;
                            bus_we_q    <= 1'b1;
                            bus_addr_q  <= {first_addr, 2'b00};
                            bus_wdata_q <= first_data;
                        end else begin
                            state_q   <= S_IDLE;
                            bus_req_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    bus_req_q <= 1'b0;
                    bus_we_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_if.cpu_rdata = '0;
        if (is_load && fwd_hit)        mem_if.cpu_rdata = fwd_data;
        else if (load_miss && rd_ack)  mem_if.cpu_rdata = mem_if.bus_rdata;
    end

    // Gated by reset so a load presented during reset does not freeze the core.
    assign mem_if.cpu_stall = rst_ni & ((load_miss & ~rd_ack) | (is_store & full & ~wr_ack));
    assign mem_if.sb_empty  = (count_q == '0) && (state_q != S_WR);
    assign mem_if.bus_req   = bus_req_q;
    assign mem_if.bus_we    = bus_we_q;
    assign mem_if.bus_addr  = bus_addr_q;
    assign mem_if.bus_wdata = bus_wdata_q;
    assign dbg_state_o      = state_q;
    assign dbg_count_o      = count_q;
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: posted stores, forwarding, full stall, load miss, reset.
module tb_dmem_store_buffer;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [1:0] dbg_state;
  logic [2:0] dbg_count;
  int         n_tests = 0;
  int         n_fail = 0;

  dmem_store_buffer_if mem_if ();

  dmem_store_buffer #(.DEPTH(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .mem_if      (mem_if),
    .dbg_state_o (dbg_state),
    .dbg_count_o (dbg_count)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_cpu(input logic en, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    mem_if.cpu_memen    = en;
    mem_if.cpu_memwrite = we;
    mem_if.cpu_addr     = addr;
    mem_if.cpu_wdata    = wdata;
  endtask

  task automatic set_bus(input logic ack, input logic [31:0] rdata);
    mem_if.bus_ack   = ack;
    mem_if.bus_rdata = rdata;
  endtask

  task automatic do_reset;
    rst_ni = 1'b0;
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_bus(1'b0, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_bus(1'b0, 32'h0);
    settle();
    chk("rst_bus_req", {31'd0, mem_if.bus_req}, 32'd0);
    chk("rst_bus_we", {31'd0, mem_if.bus_we}, 32'd0);
    chk("rst_bus_addr", mem_if.bus_addr, 32'd0);
    chk("rst_sb_empty", {31'd0, mem_if.sb_empty}, 32'd1);
    chk("rst_stall", {31'd0, mem_if.cpu_stall}, 32'd0);
    chk("rst_rdata", mem_if.cpu_rdata, 32'd0);
    chk("rst_count", {29'd0, dbg_count}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // T1: single store drains, request held while ack low
    set_cpu(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    settle();
    chk("t1_store_stall", {31'd0, mem_if.cpu_stall}, 32'd0);
    tick();
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("t1_req", {31'd0, mem_if.bus_req}, 32'd1);
    chk("t1_we", {31'd0, mem_if.bus_we}, 32'd1);
    chk("t1_addr", mem_if.bus_addr, 32'h0000_0100);
    chk("t1_wdata", mem_if.bus_wdata, 32'hDEAD_BEEF);
    chk("t1_not_empty", {31'd0, mem_if.sb_empty}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t1_req_held", {31'd0, mem_if.bus_req}, 32'd1);
      chk("t1_addr_held", mem_if.bus_addr, 32'h0000_0100);
    end
    tick();
    set_bus(1'b1, 32'h0);
    tick();
    set_bus(1'b0, 32'h0);
    settle();
    chk("t1_req_drop", {31'd0, mem_if.bus_req}, 32'd0);
    chk("t1_empty", {31'd0, mem_if.sb_empty}, 32'd1);
    chk("t1_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

    // T2: youngest buffered store forwards, no read issued
    do_reset();
    set_cpu(1'b1, 1'b1, 32'h0000_0010, 32'd1);
    tick();
    set_cpu(1'b1, 1'b1, 32'h0000_0010, 32'd2);
    tick();
    set_cpu(1'b1, 1'b0, 32'h0000_0012, 32'h0);
    settle();
    chk("t2_fwd_rdata", mem_if.cpu_rdata, 32'd2);
    chk("t2_fwd_stall", {31'd0, mem_if.cpu_stall}, 32'd0);
    chk("t2_count", {29'd0, dbg_count}, 32'd2);
    tick();
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("t2_no_read_state", {30'd0, dbg_state}, {30'd0, ST_WR});
    chk("t2_no_read_we", {31'd0, mem_if.bus_we}, 32'd1);
    chk("t2_idle_rdata", mem_if.cpu_rdata, 32'd0);

    // T3: full buffer stalls a store until a write ack frees a slot in the same cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_cpu(1'b1, 1'b1, 32'h20 + 32'(4 * i), 32'hA0 + 32'(i));
      settle();
      chk("t3_fill_stall", {31'd0, mem_if.cpu_stall}, 32'd0);
      tick();
    end
    set_cpu(1'b1, 1'b1, 32'h0000_0030, 32'hA4);
    settle();
    chk("t3_full_count", {29'd0, dbg_count}, 32'd4);
    chk("t3_full_stall", {31'd0, mem_if.cpu_stall}, 32'd1);
    tick();
    chk("t3_still_stall", {31'd0, mem_if.cpu_stall}, 32'd1);
    set_bus(1'b1, 32'h0);
    settle();
    chk("t3_ack_stall", {31'd0, mem_if.cpu_stall}, 32'd0);
    tick();
    set_bus(1'b0, 32'h0);
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("t3_count_kept", {29'd0, dbg_count}, 32'd4);
    chk("t3_next_addr", mem_if.bus_addr, 32'h0000_0024);
    chk("t3_next_wdata", mem_if.bus_wdata, 32'hA1);
    set_cpu(1'b1, 1'b0, 32'h0000_0030, 32'h0);
    settle();
    chk("t3_fwd_pushed", mem_if.cpu_rdata, 32'hA4);
    set_cpu(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    settle();
    chk("t3_popped_miss", {31'd0, mem_if.cpu_stall}, 32'd1);

    // T4: load miss from empty buffer, bus responds after three cycles
    do_reset();
    set_cpu(1'b1, 1'b0, 32'h0000_0200, 32'h0);
    settle();
    chk("t4_no_req_yet", {31'd0, mem_if.bus_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_stall", {31'd0, mem_if.cpu_stall}, 32'd1);
      chk("t4_rdata_zero", mem_if.cpu_rdata, 32'd0);
      tick();
    end
    chk("t4_rd_we", {31'd0, mem_if.bus_we}, 32'd0);
    chk("t4_rd_addr", mem_if.bus_addr, 32'h0000_0200);
    set_bus(1'b1, 32'h1234_5678);
    settle();
    chk("t4_done_stall", {31'd0, mem_if.cpu_stall}, 32'd0);
    chk("t4_rdata", mem_if.cpu_rdata, 32'h1234_5678);
    tick();
    set_bus(1'b0, 32'h0);
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("t4_req_drop", {31'd0, mem_if.bus_req}, 32'd0);
    chk("t4_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});

    // T5: load miss behind an in-flight write, then remaining store drains
    do_reset();
    set_cpu(1'b1, 1'b1, 32'h0000_0040, 32'h11);
    tick();
    set_cpu(1'b1, 1'b1, 32'h0000_0044, 32'h22);
    tick();
    set_cpu(1'b1, 1'b0, 32'h0000_0300, 32'h0);
    settle();
    chk("t5_miss_stall", {31'd0, mem_if.cpu_stall}, 32'd1);
    chk("t5_wr_addr", mem_if.bus_addr, 32'h0000_0040);
    tick();
    set_bus(1'b1, 32'h0);
    settle();
    chk("t5_wack_stall", {31'd0, mem_if.cpu_stall}, 32'd1);
    tick();
    set_bus(1'b0, 32'h0);
    settle();
    chk("t5_rd_state", {30'd0, dbg_state}, {30'd0, ST_RD});
    chk("t5_rd_we", {31'd0, mem_if.bus_we}, 32'd0);
    chk("t5_rd_addr", mem_if.bus_addr, 32'h0000_0300);
    chk("t5_count", {29'd0, dbg_count}, 32'd1);
    set_bus(1'b1, 32'hCAFE_0000);
    settle();
    chk("t5_rdata", mem_if.cpu_rdata, 32'hCAFE_0000);
    chk("t5_done_stall", {31'd0, mem_if.cpu_stall}, 32'd0);
    tick();
    set_bus(1'b0, 32'h0);
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("t5_drain_we", {31'd0, mem_if.bus_we}, 32'd1);
    chk("t5_drain_addr", mem_if.bus_addr, 32'h0000_0044);
    chk("t5_drain_wdata", mem_if.bus_wdata, 32'h22);
    set_bus(1'b1, 32'h0);
    tick();
    set_bus(1'b0, 32'h0);
    settle();
    chk("t5_final_req", {31'd0, mem_if.bus_req}, 32'd0);
    chk("t5_final_empty", {31'd0, mem_if.sb_empty}, 32'd1);

    // T6: asynchronous reset in the middle of a write
    do_reset();
    set_cpu(1'b1, 1'b1, 32'h0000_0050, 32'h55);
    tick();
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("t6_req_before", {31'd0, mem_if.bus_req}, 32'd1);
    rst_ni = 1'b0;
    settle();
    chk("t6_async_req", {31'd0, mem_if.bus_req}, 32'd0);
    chk("t6_async_empty", {31'd0, mem_if.sb_empty}, 32'd1);
    chk("t6_async_count", {29'd0, dbg_count}, 32'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_stale_req", {31'd0, mem_if.bus_req}, 32'd0);
      chk("t6_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    end

    // report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
